// File: rtl/core_if.sv
// Instruction fetch front end: one outstanding memory request at a time, results
// buffered in a 2-entry in-order FIFO toward decode, with redirect from execute.
`timescale 1ns/1ps
module core_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_in,
  input  logic [31:0] jump_addr_in,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_gnt_in,
  input  logic        mem_rvalid_in,
  input  logic [31:0] mem_rdata_in,
  output logic        inst_valid_out,
  input  logic        inst_ready_in,
  output logic [31:0] inst_out,
  output logic [31:0] inst_addr_out
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_ent_t;

  state_t           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic             discard_q, discard_d;
  fetch_ent_t [1:0] fifo_q;
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             push, pop;
  logic [31:0]      jump_pc;
  logic             unused_jump_lsb;

  assign jump_pc         = {jump_addr_in[31:2], 2'b00};
  assign unused_jump_lsb = ^jump_addr_in[1:0];

  assign mem_req_out    = (state_q == REQ);
  assign mem_addr_out   = fetch_pc_q;
  assign inst_valid_out = (count_q != 2'd0) && !jump_en_in;
  assign inst_out       = (count_q != 2'd0) ? fifo_q[rd_ptr_q].data : 32'h0;
  assign inst_addr_out  = (count_q != 2'd0) ? fifo_q[rd_ptr_q].addr : 32'h0;

  // A redirect squashes both the returning word and any pop this cycle.
  assign pop  = inst_valid_out && inst_ready_in;
  assign push = (state_q == WAIT) && mem_rvalid_in && !discard_q && !jump_en_in;

  always_comb begin
    count_d = count_q;
    if (jump_en_in)
      count_d = 2'd0;
    else
      count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    discard_d  = discard_q;
    case (state_q)
      IDLE: begin
        if (jump_en_in || (count_q < 2'd2)) state_d = REQ;
      end
      REQ: begin
        if (mem_gnt_in) begin
          state_d    = WAIT;
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          discard_d  = jump_en_in;
        end
      end
      WAIT: begin
        if (mem_rvalid_in) begin
          // Stale or redirected response: drop it and refetch at the new pc.
          if (discard_q || jump_en_in) begin
            state_d   = REQ;
            discard_d = 1'b0;
          end else begin
            state_d = (count_d < 2'd2) ? REQ : IDLE;
          end
        end else if (jump_en_in) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = REQ;
    endcase
    if (jump_en_in) fetch_pc_d = jump_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 32'h0;
      discard_q  <= 1'b0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      fifo_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      if (jump_en_in) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (push) begin
          fifo_q[wr_ptr_q] <= '{addr: req_pc_q, data: mem_rdata_in};
          wr_ptr_q         <= ~wr_ptr_q;
        end
        if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule

// File: tb/tb_core_if.sv
// Scoreboard bench for core_if: a memory responder with programmable latency,
// monitors checking granted addresses and delivered instructions against queues.
`timescale 1ns/1ps
module tb_core_if;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_en_in = 1'b0;
  logic [31:0] jump_addr_in = 32'h0;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_gnt_in = 1'b0;
  logic        mem_rvalid_in = 1'b0;
  logic [31:0] mem_rdata_in = 32'h0;
  logic        inst_valid_out;
  logic        inst_ready_in = 1'b0;
  logic [31:0] inst_out;
  logic [31:0] inst_addr_out;

  core_if #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .jump_en_in(jump_en_in), .jump_addr_in(jump_addr_in),
    .mem_req_out(mem_req_out), .mem_addr_out(mem_addr_out), .mem_gnt_in(mem_gnt_in),
    .mem_rvalid_in(mem_rvalid_in), .mem_rdata_in(mem_rdata_in),
    .inst_valid_out(inst_valid_out), .inst_ready_in(inst_ready_in),
    .inst_out(inst_out), .inst_addr_out(inst_addr_out)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_req[$];
  logic [63:0] exp_inst[$];
  int          lat = 1;
  int          gnt_cnt = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  logic        rg;
  logic [31:0] rga;
  int          base;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Memory model: word at address a is 0x13 + (a << 8).
  initial forever begin
    @(negedge clk);
    rg  = !rst && mem_req_out && mem_gnt_in;
    rga = mem_addr_out;
    if (rg) gnt_cnt++;
    @(posedge clk);
    #1;
    if (rg) begin
      pend_cnt  = lat;
      pend_addr = rga;
    end
    mem_rvalid_in = (pend_cnt == 1);
    mem_rdata_in  = (pend_cnt == 1) ? (32'h13 + (pend_addr << 8)) : 32'hDEAD_BEEF;
    if (pend_cnt > 0) pend_cnt--;
  end

  always @(negedge clk) begin
    if (!rst && mem_req_out && mem_gnt_in) begin
      if (exp_req.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL req_unexpected actual=%h expected=none", mem_addr_out);
      end else begin
        check("req_addr", mem_addr_out, exp_req.pop_front());
      end
    end
    if (!rst && inst_valid_out && inst_ready_in) begin
      if (exp_inst.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL inst_unexpected actual=%h/%h expected=none", inst_addr_out, inst_out);
      end else begin
        logic [63:0] e;
        e = exp_inst.pop_front();
        check("inst_addr", inst_addr_out, e[63:32]);
        check("inst_data", inst_out, e[31:0]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mem_gnt_in = 1'b0;
    jump_en_in = 1'b0;
    rst = 1'b1;
    cyc(4);
    rst = 1'b0;
  endtask

  task automatic wait_req(input string name);
    for (int k = 0; k < 200; k++) begin
      if (exp_req.size() == 0) break;
      cyc(1);
    end
    check(name, exp_req.size(), 32'd0);
    mem_gnt_in = 1'b0;
  endtask

  task automatic wait_inst(input string name);
    for (int k = 0; k < 200; k++) begin
      if (exp_inst.size() == 0) break;
      cyc(1);
    end
    check(name, exp_inst.size(), 32'd0);
  endtask

  initial begin
    // Basic fetch, reset outputs and grant-to-valid latency
    lat = 1; inst_ready_in = 1'b1;
    do_reset();
    mem_gnt_in = 1'b1;
    exp_req.push_back(32'h0); exp_req.push_back(32'h4); exp_req.push_back(32'h8);
    exp_inst.push_back({32'h0, 32'h13});
    exp_inst.push_back({32'h4, 32'h413});
    exp_inst.push_back({32'h8, 32'h813});
    #3;
    check("rst_mem_req", mem_req_out, 32'd1);
    check("rst_mem_addr", mem_addr_out, RST_PC);
    check("rst_inst_valid", inst_valid_out, 32'd0);
    check("rst_inst_out", inst_out, 32'h0);
    check("rst_inst_addr", inst_addr_out, 32'h0);
    cyc(1);
    check("wait_no_req", mem_req_out, 32'd0);
    cyc(1);
    check("lat_valid", inst_valid_out, 32'd1);
    check("lat_addr", inst_addr_out, 32'h0);
    wait_req("t1_req_done");
    wait_inst("t1_inst_done");

    // Backpressure: two entries buffered, no requests while full
    inst_ready_in = 1'b0;
    do_reset();
    mem_gnt_in = 1'b1;
    exp_req.push_back(32'h0); exp_req.push_back(32'h4);
    for (int k = 0; k < 50; k++) begin
      if (exp_req.size() == 0) break;
      cyc(1);
    end
    check("t2_fill_done", exp_req.size(), 32'd0);
    cyc(1);
    for (int k = 0; k < 4; k++) begin
      check("idle_no_req", mem_req_out, 32'd0);
      check("bp_head_addr", inst_addr_out, 32'h0);
      cyc(1);
    end
    exp_req.push_back(32'h8);
    exp_inst.push_back({32'h0, 32'h13});
    exp_inst.push_back({32'h4, 32'h413});
    exp_inst.push_back({32'h8, 32'h813});
    inst_ready_in = 1'b1;
    wait_req("t2_req_done");
    wait_inst("t2_inst_done");

    // Redirect while the request to 0x8 is outstanding
    lat = 3; inst_ready_in = 1'b1;
    do_reset();
    base = gnt_cnt;
    mem_gnt_in = 1'b1;
    exp_req.push_back(32'h0); exp_req.push_back(32'h4);
    exp_req.push_back(32'h8); exp_req.push_back(32'h100);
    exp_inst.push_back({32'h0, 32'h13});
    exp_inst.push_back({32'h4, 32'h413});
    exp_inst.push_back({32'h100, 32'h10013});
    for (int k = 0; k < 100; k++) begin
      if (gnt_cnt >= base + 3) break;
      cyc(1);
    end
    check("t3_third_grant", gnt_cnt - base, 32'd3);
    jump_en_in = 1'b1; jump_addr_in = 32'h100;
    cyc(1);
    jump_en_in = 1'b0;
    check("t3_new_pc", mem_addr_out, 32'h100);
    wait_req("t3_req_done");
    wait_inst("t3_inst_done");

    // Redirect in the grant cycle, unaligned target
    lat = 1;
    do_reset();
    mem_gnt_in = 1'b1;
    jump_en_in = 1'b1; jump_addr_in = 32'h203;
    exp_req.push_back(32'h0); exp_req.push_back(32'h200); exp_req.push_back(32'h204);
    exp_inst.push_back({32'h200, 32'h20013});
    exp_inst.push_back({32'h204, 32'h20413});
    cyc(1);
    jump_en_in = 1'b0;
    check("t4_new_pc", mem_addr_out, 32'h200);
    wait_req("t4_req_done");
    wait_inst("t4_inst_done");

    // Reset while a request is outstanding with an entry buffered
    lat = 3; inst_ready_in = 1'b0;
    do_reset();
    base = gnt_cnt;
    mem_gnt_in = 1'b1;
    exp_req.push_back(32'h0); exp_req.push_back(32'h4);
    for (int k = 0; k < 100; k++) begin
      if (gnt_cnt >= base + 2) break;
      cyc(1);
    end
    check("t5_second_grant", gnt_cnt - base, 32'd2);
    mem_gnt_in = 1'b0;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("t5_valid", inst_valid_out, 32'd0);
    check("t5_req", mem_req_out, 32'd1);
    check("t5_addr", mem_addr_out, RST_PC);
    check("t5_inst_out", inst_out, 32'h0);
    inst_ready_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      check("t5_no_push", inst_valid_out, 32'd0);
    end
    lat = 1;
    exp_req.push_back(32'h0);
    exp_inst.push_back({32'h0, 32'h13});
    mem_gnt_in = 1'b1;
    wait_req("t5_req_done");
    wait_inst("t5_inst_done");

    // Redirect without grant to the top word, then wrap-around
    lat = 1; inst_ready_in = 1'b1;
    do_reset();
    jump_en_in = 1'b1; jump_addr_in = 32'hFFFF_FFFC;
    cyc(1);
    jump_en_in = 1'b0;
    check("t6_req", mem_req_out, 32'd1);
    check("t6_addr", mem_addr_out, 32'hFFFF_FFFC);
    exp_req.push_back(32'hFFFF_FFFC); exp_req.push_back(32'h0); exp_req.push_back(32'h4);
    exp_inst.push_back({32'hFFFF_FFFC, 32'hFFFF_FC13});
    exp_inst.push_back({32'h0, 32'h13});
    exp_inst.push_back({32'h4, 32'h413});
    mem_gnt_in = 1'b1;
    wait_req("t6_req_done");
    wait_inst("t6_inst_done");

    // Redirect from IDLE with a full FIFO flushes it
    inst_ready_in = 1'b0;
    do_reset();
    mem_gnt_in = 1'b1;
    exp_req.push_back(32'h0); exp_req.push_back(32'h4);
    for (int k = 0; k < 50; k++) begin
      if (exp_req.size() == 0) break;
      cyc(1);
    end
    check("t7_fill_done", exp_req.size(), 32'd0);
    cyc(1);
    check("t7_full_valid", inst_valid_out, 32'd1);
    exp_req.push_back(32'h40);
    jump_en_in = 1'b1; jump_addr_in = 32'h40;
    #1;
    check("t7_jump_masks_valid", inst_valid_out, 32'd0);
    cyc(1);
    jump_en_in = 1'b0;
    check("t7_flushed", inst_valid_out, 32'd0);
    exp_inst.push_back({32'h40, 32'h4013});
    inst_ready_in = 1'b1;
    wait_req("t7_req_done");
    wait_inst("t7_inst_done");

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
